// File: rtl/lib_switch_onehot_elastic.sv
// NxM one-hot-select crossbar with atomic multicast and a bubble-collapsing
// elastic pipeline of DEPTH register stages on every output lane.
module lib_switch_onehot_elastic #(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [M-1:0][N-1:0]     i_sel,
  input  logic [N-1:0]            i_valid,
  input  logic [N-1:0][WIDTH-1:0] i_data,
  output logic [N-1:0]            o_in_ready,
  output logic [M-1:0]            o_valid,
  output logic [M-1:0][WIDTH-1:0] o_data,
  input  logic [M-1:0]            i_out_ready,
  output logic [M-1:0]            o_sel_err
);

  logic [M-1:0]            legal;
  logic [M-1:0][N-1:0]     hit;
  logic [M-1:0]            lane_rdy;
  logic [N-1:0]            accept;
  logic [M-1:0]            lane_load;
  logic [M-1:0][WIDTH-1:0] lane_din;
  logic [M-1:0]            sel_err_d, sel_err_q;

  // Multi-hot selects are treated as idle and flagged one cycle later.
  always_comb begin
    for (int m = 0; m < int'(M); m++) begin
      legal[m]     = $onehot(i_sel[m]);
      hit[m]       = legal[m] ? i_sel[m] : '0;
      sel_err_d[m] = (i_sel[m] != '0) && !legal[m];
    end
  end

  // An input is ready only when every lane selecting it can take a packet,
  // so a multicast is captured by all target lanes or by none.
  always_comb begin
    logic any_hit;
    logic all_rdy;
    o_in_ready = '0;
    for (int j = 0; j < int'(N); j++) begin
      any_hit = 1'b0;
      all_rdy = 1'b1;
      for (int m = 0; m < int'(M); m++) begin
        if (hit[m][j]) begin
          any_hit = 1'b1;
          all_rdy = all_rdy & lane_rdy[m];
        end
      end
      o_in_ready[j] = any_hit & all_rdy;
    end
  end

  assign accept = i_valid & o_in_ready;

  always_comb begin
    lane_load = '0;
    lane_din  = '0;
    for (int m = 0; m < int'(M); m++) begin
      for (int j = 0; j < int'(N); j++) begin
        if (hit[m][j] && accept[j]) begin
          lane_load[m] = 1'b1;
          lane_din[m]  = i_data[j];
        end
      end
    end
  end

  for (genvar m = 0; m < int'(M); m++) begin : g_lane
    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0][WIDTH-1:0] d_q;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0]            in_v;
    logic [DEPTH-1:0][WIDTH-1:0] in_d;

    assign in_v[0] = lane_load[m];
    assign in_d[0] = lane_din[m];
    for (genvar k = 1; k < int'(DEPTH); k++) begin : g_fwd
      assign in_v[k] = v_q[k-1];
      assign in_d[k] = d_q[k-1];
    end

    // A stage can take a packet if it is empty or its occupant moves on.
    always_comb begin
      logic r;
      r   = i_out_ready[m];
      rdy = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
        r      = ~v_q[k] | r;
        rdy[k] = r;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (rdy[k]) begin
            v_q[k] <= in_v[k];
            if (in_v[k]) begin
              d_q[k] <= in_d[k];
            end
          end
        end
      end
    end

    assign lane_rdy[m] = rdy[0];
    assign o_valid[m]  = v_q[DEPTH-1];
    assign o_data[m]   = d_q[DEPTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_q <= '0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign o_sel_err = sel_err_q;

endmodule

// File: tb/tb_lib_switch_onehot_elastic.sv
// Bench for lib_switch_onehot_elastic: per-lane scoreboard plus scenario tasks,
// and a second DEPTH=1, N=2, M=3 instance for full-rate streaming.
module tb_lib_switch_onehot_elastic;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int W  = 64;
  localparam int D  = 2;
  localparam int NB = 2;
  localparam int MB = 3;

  typedef struct packed {
    logic [W-1:0] data;
    int unsigned  vis;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [M-1:0][N-1:0] sel;
  logic [N-1:0]        in_valid;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]        in_ready;
  logic [M-1:0]        out_valid;
  logic [M-1:0][W-1:0] out_data;
  logic [M-1:0]        out_rdy;
  logic [M-1:0]        sel_err;

  logic [MB-1:0][NB-1:0] b_sel;
  logic [NB-1:0]         b_valid;
  logic [NB-1:0][W-1:0]  b_data;
  logic [NB-1:0]         b_in_ready;
  logic [MB-1:0]         b_out_valid;
  logic [MB-1:0][W-1:0]  b_out_data;
  logic [MB-1:0]         b_out_rdy;
  logic [MB-1:0]         b_sel_err;

  lib_switch_onehot_elastic #(.N(N), .M(M), .WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_sel      (sel),
    .i_valid    (in_valid),
    .i_data     (in_data),
    .o_in_ready (in_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .i_out_ready(out_rdy),
    .o_sel_err  (sel_err)
  );

  lib_switch_onehot_elastic #(.N(NB), .M(MB), .WIDTH(W), .DEPTH(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .i_sel      (b_sel),
    .i_valid    (b_valid),
    .i_data     (b_data),
    .o_in_ready (b_in_ready),
    .o_valid    (b_out_valid),
    .o_data     (b_out_data),
    .i_out_ready(b_out_rdy),
    .o_sel_err  (b_sel_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  exp_t sbq [M][$];
  logic [M-1:0] err_m = '0;

  logic [M-1:0] m_legal, m_room, m_expv;
  logic [N-1:0] m_rdy;
  logic         m_any, m_all;
  exp_t         m_e;

  // Scoreboard: compare at negedge, then apply the handshakes of the coming edge.
  initial forever begin
    @(negedge clk);
    if (mon_en && !reset) begin
      for (int m = 0; m < M; m++) begin
        m_legal[m] = $onehot(sel[m]);
        m_room[m]  = (sbq[m].size() < D) || out_rdy[m];
        m_expv[m]  = (sbq[m].size() > 0) && (cyc >= sbq[m][0].vis);
      end
      for (int j = 0; j < N; j++) begin
        m_any = 1'b0;
        m_all = 1'b1;
        for (int m = 0; m < M; m++) begin
          if (m_legal[m] && sel[m][j]) begin
            m_any = 1'b1;
            if (!m_room[m]) m_all = 1'b0;
          end
        end
        m_rdy[j] = m_any & m_all;
      end
      n_cmp++;
      if (in_ready !== m_rdy) begin
        n_err++;
        $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, m_rdy);
      end
      for (int m = 0; m < M; m++) begin
        n_cmp++;
        if (out_valid[m] !== m_expv[m]) begin
          n_err++;
          $display("FAIL out_valid[%0d] cyc=%0d got=%b want=%b", m, cyc, out_valid[m], m_expv[m]);
        end
        if (m_expv[m]) begin
          n_cmp++;
          if (out_data[m] !== sbq[m][0].data) begin
            n_err++;
            $display("FAIL out_data[%0d] cyc=%0d got=%h want=%h", m, cyc, out_data[m],
                     sbq[m][0].data);
          end
        end
        n_cmp++;
        if (sel_err[m] !== err_m[m]) begin
          n_err++;
          $display("FAIL sel_err[%0d] cyc=%0d got=%b want=%b", m, cyc, sel_err[m], err_m[m]);
        end
      end
      for (int m = 0; m < M; m++) begin
        if (m_expv[m] && out_rdy[m]) void'(sbq[m].pop_front());
      end
      for (int j = 0; j < N; j++) begin
        if (in_valid[j] && m_rdy[j]) begin
          for (int m = 0; m < M; m++) begin
            if (m_legal[m] && sel[m][j]) begin
              m_e.data = in_data[j];
              m_e.vis  = cyc + D;
              sbq[m].push_back(m_e);
            end
          end
        end
      end
      for (int m = 0; m < M; m++) err_m[m] = (sel[m] != '0) && !m_legal[m];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    sel      = '0;
    in_valid = '0;
    out_rdy  = '1;
    repeat (D + 2) tick();
    for (int m = 0; m < M; m++) begin
      n_cmp++;
      if (sbq[m].size() != 0) begin
        n_err++;
        $display("FAIL drain lane %0d left=%0d want=0", m, sbq[m].size());
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel = '0; in_valid = '0; in_data = '0; out_rdy = '0;
    b_sel = '0; b_valid = '0; b_data = '0; b_out_rdy = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== '0 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_out got=%b/%h want=0/0", out_valid, out_data);
    end
    n_cmp++;
    if (sel_err !== '0 || in_ready !== '0) begin
      n_err++;
      $display("FAIL reset_flags err=%b rdy=%b want=0/0", sel_err, in_ready);
    end
    n_cmp++;
    if (b_out_valid !== '0) begin
      n_err++;
      $display("FAIL reset_b_valid got=%b want=0", b_out_valid);
    end
    #1 reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_unicast();
    out_rdy = '1;
    sel = '0;
    sel[2] = 4'b0010;
    in_valid = 4'b0010;
    in_data[1] = 64'hA5A5;
    @(negedge clk);
    n_cmp++;
    if (in_ready[1] !== 1'b1 || out_valid !== '0) begin
      n_err++;
      $display("FAIL unicast_present rdy=%b valid=%b want=1/0000", in_ready[1], out_valid);
    end
    tick();
    in_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== '0) begin
      n_err++;
      $display("FAIL unicast_early valid=%b want=0000", out_valid);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 4'b0100 || out_data[2] !== 64'hA5A5) begin
      n_err++;
      $display("FAIL unicast_out valid=%b data=%h want=0100/a5a5", out_valid, out_data[2]);
    end
    tick();
    drain();
  endtask

  task automatic test_multicast();
    bit found = 1'b0;
    sel = '0;
    out_rdy = 4'b0111;
    sel[3] = 4'b1000;
    in_valid = 4'b1000;
    in_data[3] = 64'h31;
    tick();
    in_data[3] = 64'h32;
    tick();
    sel[0] = 4'b1000;
    in_data[3] = 64'h77;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready[3] !== 1'b0 || out_valid[0] !== 1'b0) begin
        n_err++;
        $display("FAIL mcast_stall rdy=%b lane0=%b want=0/0", in_ready[3], out_valid[0]);
      end
      tick();
    end
    out_rdy[3] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready[3] !== 1'b1) begin
      n_err++;
      $display("FAIL mcast_release rdy=%b want=1", in_ready[3]);
    end
    tick();
    in_valid = '0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) begin
        found = 1'b1;
        n_cmp++;
        if (out_valid[3] !== 1'b1 || out_data[3] !== 64'h77 || out_data[0] !== 64'h77) begin
          n_err++;
          $display("FAIL mcast_same_cycle v3=%b d0=%h d3=%h want=1/77/77", out_valid[3],
                   out_data[0], out_data[3]);
        end
      end
      tick();
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mcast_timeout lane0 valid never seen, want within 6 cycles");
    end
    drain();
  endtask

  task automatic test_backpressure();
    int nxt = 1;
    int acc_stall = 0;
    logic acc;
    sel = '0;
    sel[1] = 4'b0001;
    out_rdy = 4'b1101;
    in_valid = 4'b0001;
    for (int c = 0; c < 40 && nxt <= 6; c++) begin
      in_data[0] = 64'(nxt);
      if (c == 4) out_rdy[1] = 1'b1;
      @(negedge clk);
      acc = in_ready[0];
      if (c < 4 && acc) acc_stall++;
      tick();
      if (acc) nxt++;
    end
    in_valid = '0;
    n_cmp++;
    if (acc_stall != 2) begin
      n_err++;
      $display("FAIL bp_accepts_while_stalled got=%0d want=2", acc_stall);
    end
    n_cmp++;
    if (nxt != 7) begin
      n_err++;
      $display("FAIL bp_sent got=%0d want=7", nxt);
    end
    drain();
  endtask

  task automatic test_sel_err();
    sel = '0;
    out_rdy = '1;
    sel[1] = 4'b0110;
    in_valid = '1;
    for (int j = 0; j < N; j++) in_data[j] = {$urandom, $urandom};
    @(negedge clk);
    n_cmp++;
    if (in_ready !== '0) begin
      n_err++;
      $display("FAIL selerr_ready got=%b want=0000", in_ready);
    end
    tick();
    sel = '0;
    in_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (sel_err !== 4'b0010 || out_valid !== '0) begin
      n_err++;
      $display("FAIL selerr_pulse err=%b valid=%b want=0010/0000", sel_err, out_valid);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (sel_err !== '0 || out_valid !== '0) begin
      n_err++;
      $display("FAIL selerr_clear err=%b valid=%b want=0000/0000", sel_err, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    sel = '0;
    sel[0] = 4'b0001;
    sel[2] = 4'b0100;
    out_rdy = 4'b1010;
    in_valid = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      in_data[0] = 64'h100 + 64'(c);
      in_data[2] = 64'h200 + 64'(c);
      tick();
    end
    in_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 4'b0101) begin
      n_err++;
      $display("FAIL rst_pre_full valid=%b want=0101", out_valid);
    end
    #1 reset = 1'b1;
    for (int m = 0; m < M; m++) sbq[m].delete();
    err_m = '0;
    #1;
    n_cmp++;
    if (out_valid !== '0 || out_data !== '0) begin
      n_err++;
      $display("FAIL rst_async valid=%b data=%h want=0/0", out_valid, out_data);
    end
    #1 reset = 1'b0;
    tick();
    sel[0] = 4'b0001;
    out_rdy = '1;
    in_valid = 4'b0001;
    in_data[0] = 64'hBEEF;
    tick();
    in_valid = '0;
    repeat (D - 1) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid[0] !== 1'b0) begin
        n_err++;
        $display("FAIL rst_latency_early valid=%b want=0", out_valid[0]);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 64'hBEEF) begin
      n_err++;
      $display("FAIL rst_latency valid=%b data=%h want=1/beef", out_valid[0], out_data[0]);
    end
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    int unsigned r;
    for (int c = 0; c < 300; c++) begin
      for (int m = 0; m < M; m++) begin
        r = $urandom_range(0, 7);
        if (r == 0) sel[m] = '0;
        else if (r == 7) sel[m] = 4'(4'b0011 << $urandom_range(0, 2));
        else sel[m] = 4'(4'b0001 << $urandom_range(0, N - 1));
        out_rdy[m] = ($urandom_range(0, 3) != 0);
      end
      in_valid = 4'($urandom);
      for (int j = 0; j < N; j++) in_data[j] = {$urandom, $urandom};
      tick();
    end
    drain();
  endtask

  task automatic test_depth1();
    logic [W-1:0] qb [MB][$];
    logic [W-1:0] e;
    b_sel[0] = 2'b01;
    b_sel[1] = 2'b10;
    b_sel[2] = 2'b01;
    b_valid = 2'b11;
    b_out_rdy = '1;
    for (int c = 0; c <= 12; c++) begin
      if (c == 12) b_valid = '0;
      b_data[0] = 64'h1000 + 64'(c);
      b_data[1] = 64'h2000 + 64'(c);
      @(negedge clk);
      if (c < 12) begin
        n_cmp++;
        if (b_in_ready !== 2'b11) begin
          n_err++;
          $display("FAIL d1_ready c=%0d got=%b want=11", c, b_in_ready);
        end
      end
      for (int m = 0; m < MB; m++) begin
        n_cmp++;
        if (qb[m].size() > 0) begin
          e = qb[m].pop_front();
          if (b_out_valid[m] !== 1'b1 || b_out_data[m] !== e) begin
            n_err++;
            $display("FAIL d1_lane%0d c=%0d got=%b/%h want=1/%h", m, c, b_out_valid[m],
                     b_out_data[m], e);
          end
        end else if (b_out_valid[m] !== 1'b0) begin
          n_err++;
          $display("FAIL d1_idle%0d c=%0d got=%b want=0", m, c, b_out_valid[m]);
        end
      end
      if (c < 12) begin
        qb[0].push_back(b_data[0]);
        qb[1].push_back(b_data[1]);
        qb[2].push_back(b_data[0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_sel_err();
    test_reset_midstream();
    test_back_to_back();
    test_depth1();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
